// File: rtl/date_disp_pkg.sv
// Shared types and default dates for the six-digit birthday display path.
package date_disp_pkg;

   localparam int NUM_DIGITS = 6;

   // Dates are packed as six BCD nibbles, [23:20] feeding HEX5 down to [3:0] feeding HEX0.
   localparam logic [23:0] DATE_A_DEFAULT = 24'h030200;
   localparam logic [23:0] DATE_B_DEFAULT = 24'h080700;

   typedef logic [3:0] bcd_digit_t;
   typedef bcd_digit_t [NUM_DIGITS-1:0] date_bcd_t;

   typedef enum logic {
      SHOW_A = 1'b0,
      SHOW_B = 1'b1
   } date_state_t;

   // The display only ever alternates between the two dates.
   function automatic date_state_t other_date(input date_state_t s);
      return (s == SHOW_A) ? SHOW_B : SHOW_A;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus counting debouncer for an active-low push button.
// After reset the button must first be seen stably released before any press is
// accepted, so a button held through reset never produces a press on its own.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic key_db,
   output logic press
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          key_s_q, key_s_d;
   logic          key_db_q, key_db_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic          armed_q, armed_d;
   logic          press_q, press_d;

   // Synchronise, then require DEBOUNCE_CYCLES consecutive differing samples to move key_db.
   always_comb begin
      sync1_d  = key_n;
      key_s_d  = sync1_q;
      key_db_d = key_db_q;
      db_cnt_d = db_cnt_q;
      armed_d  = armed_q;
      press_d  = 1'b0;
      if (!armed_q) begin
         // Waiting for a stable release; key_db stays high meanwhile.
         if (!key_s_q) begin
            db_cnt_d = '0;
         end else if (db_cnt_q == DB_LAST) begin
            armed_d  = 1'b1;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end else if (key_s_q == key_db_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         key_db_d = key_s_q;
         db_cnt_d = '0;
         press_d  = ~key_s_q;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   // State registers; sync flops and key_db idle high (released).
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b1;
         key_s_q  <= 1'b1;
         key_db_q <= 1'b1;
         db_cnt_q <= '0;
         armed_q  <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         key_s_q  <= key_s_d;
         key_db_q <= key_db_d;
         db_cnt_q <= db_cnt_d;
         armed_q  <= armed_d;
         press_q  <= press_d;
      end
   end

   assign key_db = key_db_q;
   assign press  = press_q;

endmodule

// File: rtl/date_select_ctrl.sv
// Date selection control: alternates the displayed date on each debounced press
// or periodically when auto_en is high, and drives registered packed BCD digits.
module date_select_ctrl
   import date_disp_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned AUTO_CYCLES     = 100000000,
   parameter logic [23:0] DATE_A          = DATE_A_DEFAULT,
   parameter logic [23:0] DATE_B          = DATE_B_DEFAULT
) (
   input  logic        MAX10_CLK1_50,
   input  logic        rst,
   input  logic        key_n,
   input  logic        auto_en,
   output logic [23:0] digits,
   output logic        sel,
   output logic        press_pulse
);

   localparam int AW = $clog2(AUTO_CYCLES);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);
   localparam date_bcd_t DATE_A_BCD = DATE_A;
   localparam date_bcd_t DATE_B_BCD = DATE_B;

   logic          key_db;
   logic          press;
   logic          press_ok;
   logic          auto_term;
   logic          toggle;
   date_state_t   state_q, state_d;
   logic [AW-1:0] auto_cnt_q, auto_cnt_d;
   logic [23:0]   digits_q, digits_d;
   logic          sel_q, sel_d;
   logic          press_pulse_q, press_pulse_d;
   date_bcd_t     next_digits;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clk    (MAX10_CLK1_50),
      .rst    (rst),
      .key_n  (key_n),
      .key_db (key_db),
      .press  (press)
   );

   // Press strobe is honoured only while the debounced level is still low (always true in practice).
   assign press_ok = press & ~key_db;

   // Next date and auto counter: press and terminal count together still give one toggle.
   always_comb begin
      auto_term = auto_en && (auto_cnt_q == AUTO_LAST);
      toggle    = press_ok || auto_term;
      state_d   = toggle ? other_date(state_q) : state_q;
      if (!auto_en || press_ok || auto_term) begin
         auto_cnt_d = '0;
      end else begin
         auto_cnt_d = auto_cnt_q + 1'b1;
      end
   end

   // Per-digit selection of the date that the next state shows.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign next_digits[gi] = (state_d == SHOW_B) ? DATE_B_BCD[gi] : DATE_A_BCD[gi];
   end

   // Output values are computed from the next state so they register alongside it.
   always_comb begin
      sel_d         = (state_d == SHOW_B);
      digits_d      = next_digits;
      press_pulse_d = press_ok;
   end

   // FSM, counter and output registers.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (rst) begin
         state_q       <= SHOW_A;
         auto_cnt_q    <= '0;
         digits_q      <= DATE_A;
         sel_q         <= 1'b0;
         press_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         auto_cnt_q    <= auto_cnt_d;
         digits_q      <= digits_d;
         sel_q         <= sel_d;
         press_pulse_q <= press_pulse_d;
      end
   end

   assign digits      = digits_q;
   assign sel         = sel_q;
   assign press_pulse = press_pulse_q;

endmodule

// File: tb/tb_date_select_ctrl.sv
// Self-checking bench for date_select_ctrl with a timestamp/queue based reference model.
module tb_date_select_ctrl;

   localparam int DBC = 4;
   localparam int AC  = 10;
   localparam logic [23:0] DA = 24'h030200;
   localparam logic [23:0] DB = 24'h080700;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_n = 1'b1;
   logic        auto_en = 1'b0;
   logic [23:0] digits;
   logic        sel;
   logic        press_pulse;

   int total = 0;
   int bad   = 0;

   date_select_ctrl #(
      .DEBOUNCE_CYCLES(DBC),
      .AUTO_CYCLES    (AC),
      .DATE_A         (DA),
      .DATE_B         (DB)
   ) dut (
      .MAX10_CLK1_50(clk),
      .rst          (rst),
      .key_n        (key_n),
      .auto_en      (auto_en),
      .digits       (digits),
      .sel          (sel),
      .press_pulse  (press_pulse)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int unsigned edge_no = 0;
   int unsigned m_clear_edge = 0;   // edge at which the auto period last restarted
   bit m_s1 = 1, m_s2 = 1, m_db = 1, m_armed = 0, m_press_pend = 0, m_sel = 0, m_pulse = 0;
   bit hist[$];                     // consecutive samples arguing for a change

   function automatic logic [23:0] m_digits();
      return m_sel ? DB : DA;
   endfunction

   task automatic model_edge();
      bit ks, press_ev, auto_ev;
      edge_no++;
      if (rst) begin
         m_s1 = 1; m_s2 = 1; m_db = 1; m_armed = 0; m_press_pend = 0;
         m_sel = 0; m_pulse = 0; hist.delete(); m_clear_edge = edge_no;
         return;
      end
      ks       = m_s2;
      press_ev = m_press_pend;
      auto_ev  = auto_en && ((edge_no - m_clear_edge) == AC);
      if (press_ev || auto_ev) m_sel = !m_sel;
      m_pulse = press_ev;
      if (!auto_en || press_ev || auto_ev) m_clear_edge = edge_no;
      m_press_pend = 0;
      if (!m_armed) begin
         if (!ks) hist.delete(); else hist.push_back(ks);
         if (hist.size() == DBC) begin m_armed = 1; hist.delete(); end
      end else begin
         if (ks == m_db) hist.delete(); else hist.push_back(ks);
         if (hist.size() == DBC) begin
            m_db = ks; hist.delete(); m_press_pend = !ks;
         end
      end
      m_s2 = m_s1;
      m_s1 = key_n;
   endtask

   // Advance one clock; inputs are stable across the edge, outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if ({digits, sel, press_pulse} !== {DA, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values got digits=%h sel=%0b pulse=%0b want %h 0 0", digits, sel, press_pulse, DA);
         end
      end
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if ({sel, digits, press_pulse} !== {m_sel, m_digits(), m_pulse}) begin
            bad++;
            $display("FAIL reset_idle edge=%0d got %0b %h %0b want %0b %h %0b", edge_no, sel, digits, press_pulse, m_sel, m_digits(), m_pulse);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [63:0] pmask = '0;
      logic [63:0] tmask = '0;
      logic prev, sel0;
      sel0 = m_sel;
      prev = sel;
      key_n = 0;
      for (int i = 1; i <= 35; i++) begin
         tick();
         total++;
         if ({sel, digits, press_pulse} !== {m_sel, m_digits(), m_pulse}) begin
            bad++;
            $display("FAIL press_model edge=%0d got %0b %h %0b want %0b %h %0b", i, sel, digits, press_pulse, m_sel, m_digits(), m_pulse);
         end
         if (press_pulse) pmask[i] = 1'b1;
         if (sel !== prev) tmask[i] = 1'b1;
         prev = sel;
         if (i == 20) key_n = 1;
      end
      total++;
      if (pmask !== (64'd1 << 7) || tmask !== (64'd1 << 7)) begin
         bad++;
         $display("FAIL press_timing got pulses=%h toggles=%h want both %h", pmask, tmask, 64'd1 << 7);
      end
      total++;
      if ({sel, digits} !== {~sel0, (sel0 ? DA : DB)}) begin
         bad++;
         $display("FAIL press_result got sel=%0b digits=%h want sel=%0b digits=%h", sel, digits, ~sel0, sel0 ? DA : DB);
      end
   endtask

   task automatic test_glitch();
      for (int len = 1; len <= DBC; len++) begin
         logic [63:0] pmask = '0;
         logic sel0;
         sel0 = sel;
         key_n = 0;
         for (int i = 1; i <= 16; i++) begin
            tick();
            total++;
            if ({sel, digits, press_pulse} !== {m_sel, m_digits(), m_pulse}) begin
               bad++;
               $display("FAIL glitch_model len=%0d edge=%0d got %0b %h %0b want %0b %h %0b", len, i, sel, digits, press_pulse, m_sel, m_digits(), m_pulse);
            end
            if (press_pulse) pmask[i] = 1'b1;
            if (i == len) key_n = 1;
         end
         total++;
         if (pmask !== ((len == DBC) ? (64'd1 << 7) : 64'd0) || sel !== ((len == DBC) ? ~sel0 : sel0)) begin
            bad++;
            $display("FAIL glitch_len%0d got pulses=%h sel=%0b want accept=%0d", len, pmask, sel, len == DBC);
         end
      end
   endtask

   task automatic test_auto();
      logic [63:0] tmask = '0;
      logic [63:0] pmask = '0;
      logic prev;
      prev = sel;
      auto_en = 1;
      for (int i = 1; i <= 35; i++) begin
         tick();
         total++;
         if ({sel, digits, press_pulse} !== {m_sel, m_digits(), m_pulse}) begin
            bad++;
            $display("FAIL auto_model edge=%0d got %0b %h %0b want %0b %h %0b", i, sel, digits, press_pulse, m_sel, m_digits(), m_pulse);
         end
         if (sel !== prev) tmask[i] = 1'b1;
         if (press_pulse) pmask[i] = 1'b1;
         prev = sel;
      end
      total++;
      if (tmask !== ((64'd1 << 10) | (64'd1 << 20) | (64'd1 << 30)) || pmask !== 64'd0) begin
         bad++;
         $display("FAIL auto_period got toggles=%h pulses=%h", tmask, pmask);
      end
      // Deassert mid-count, then reassert: a full period restarts from the reassertion.
      auto_en = 0;
      tick();
      tmask = '0;
      auto_en = 1;
      for (int i = 1; i <= 22; i++) begin
         tick();
         total++;
         if ({sel, digits, press_pulse} !== {m_sel, m_digits(), m_pulse}) begin
            bad++;
            $display("FAIL auto_restart_model edge=%0d got %0b %h %0b want %0b %h %0b", i, sel, digits, press_pulse, m_sel, m_digits(), m_pulse);
         end
         if (sel !== prev) tmask[i] = 1'b1;
         prev = sel;
         if (i == 6) auto_en = 0;
         if (i == 8) auto_en = 1;
      end
      auto_en = 0;
      total++;
      if (tmask !== (64'd1 << 18)) begin
         bad++;
         $display("FAIL auto_restart got toggles=%h want %h", tmask, 64'd1 << 18);
      end
      tick();
   endtask

   task automatic test_simultaneous();
      logic [63:0] tmask = '0;
      logic [63:0] pmask = '0;
      logic prev;
      prev = sel;
      auto_en = 1;
      for (int i = 1; i <= 36; i++) begin
         tick();
         total++;
         if ({sel, digits, press_pulse} !== {m_sel, m_digits(), m_pulse}) begin
            bad++;
            $display("FAIL simul_model edge=%0d got %0b %h %0b want %0b %h %0b", i, sel, digits, press_pulse, m_sel, m_digits(), m_pulse);
         end
         if (sel !== prev) tmask[i] = 1'b1;
         if (press_pulse) pmask[i] = 1'b1;
         prev = sel;
         if (i == 13) key_n = 0;
         if (i == 25) key_n = 1;
      end
      auto_en = 0;
      total++;
      if (tmask !== ((64'd1 << 10) | (64'd1 << 20) | (64'd1 << 30)) || pmask !== (64'd1 << 20)) begin
         bad++;
         $display("FAIL simul_events got toggles=%h pulses=%h", tmask, pmask);
      end
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_reset_mid();
      logic [63:0] tmask = '0;
      logic prev;
      // Reset two samples into the debounce window while the button is held.
      key_n = 0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1;
      tick();
      total++;
      if ({digits, sel, press_pulse} !== {DA, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_mid_debounce got %h %0b %0b want %h 0 0", digits, sel, press_pulse, DA);
      end
      tick();
      rst = 0;
      prev = sel;
      for (int i = 1; i <= 50; i++) begin
         tick();
         total++;
         if ({sel, digits, press_pulse} !== {m_sel, m_digits(), m_pulse}) begin
            bad++;
            $display("FAIL reset_hold_model edge=%0d got %0b %h %0b want %0b %h %0b", i, sel, digits, press_pulse, m_sel, m_digits(), m_pulse);
         end
         if (sel !== prev) tmask[i] = 1'b1;
         prev = sel;
         if (i == 20) key_n = 1;
         if (i == 30) key_n = 0;
         if (i == 45) key_n = 1;
      end
      total++;
      if (tmask !== (64'd1 << 37)) begin
         bad++;
         $display("FAIL reset_held_button got toggles=%h want %h", tmask, 64'd1 << 37);
      end
      // Reach SHOW_B, then reset with a fresh press in flight.
      for (int t = 0; t < 2 && !m_sel; t++) begin
         key_n = 0;
         for (int i = 0; i < 10; i++) tick();
         key_n = 1;
         for (int i = 0; i < 12; i++) tick();
      end
      total++;
      if (sel !== 1'b1 || digits !== DB) begin
         bad++;
         $display("FAIL pre_reset_showb got sel=%0b digits=%h want 1 %h", sel, digits, DB);
      end
      key_n = 0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1;
      tick();
      total++;
      if ({digits, sel, press_pulse} !== {DA, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_from_showb got %h %0b %0b want %h 0 0", digits, sel, press_pulse, DA);
      end
      rst = 0;
      key_n = 1;
      for (int i = 0; i < 10; i++) tick();
   endtask

   task automatic test_random();
      int run_left = 0;
      for (int i = 0; i < 800; i++) begin
         if (run_left == 0) begin
            key_n = 1'($urandom_range(0, 1));
            run_left = $urandom_range(1, 8);
         end
         run_left--;
         if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
         rst = ($urandom_range(0, 199) == 0);
         tick();
         total++;
         if ({sel, digits, press_pulse} !== {m_sel, m_digits(), m_pulse}) begin
            bad++;
            $display("FAIL random_model cycle=%0d got %0b %h %0b want %0b %h %0b", i, sel, digits, press_pulse, m_sel, m_digits(), m_pulse);
         end
      end
      rst = 0;
      auto_en = 0;
      key_n = 1;
   endtask

   initial begin
      #1;
      test_reset();
      test_clean_press();
      test_glitch();
      test_auto();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/date_select_ctrl.md
# date_select_ctrl

Upstream control stage for the six-digit birthday display. It synchronises and debounces the raw active-low push button. It alternates between two stored dates, either on each debounced press or automatically on a fixed period. It drives the six packed BCD digits that the downstream seven-segment decode stage consumes, and replaces the undebounced level-sensitive selection with a clean, registered toggle.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000 — consecutive stable synchronised samples required to accept a button level change (10 ms at 50 MHz); minimum 2.
- AUTO_CYCLES, 100000000 — auto-alternate period in clocks (2 s at 50 MHz); minimum 2.
- DATE_A, 24'h030200 — date A as six BCD nibbles; [23:20] drives HEX5, down to [3:0] for HEX0.
- DATE_B, 24'h080700 — date B, same packing.

Ports:
- MAX10_CLK1_50  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- key_n  in  1  raw push button, active-low (0 = pressed), asynchronous to the clock.
- auto_en  in  1  level input; 1 enables periodic auto-alternation.
- digits  out  24  registered BCD digits of the selected date.
- sel  out  1  registered; 0 = DATE_A shown, 1 = DATE_B shown.
- press_pulse  out  1  registered one-cycle strobe on each accepted press.

## Operation
- Synchroniser: two flops on key_n, both reset to 1. Call the synchronised output key_s.
- Debouncer:
  - The debounced level key_db resets to 1. A counter db_cnt, ceil(log2(DEBOUNCE_CYCLES)) bits, resets to 0.
  - When key_s == key_db, db_cnt clears to 0.
  - Otherwise db_cnt increments. When db_cnt == DEBOUNCE_CYCLES-1 and key_s still differs, key_db takes key_s and db_cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes key_db.
- Press detect: a key_db transition 1→0 is a press. Release (0→1) produces no event.
- State machine date_state, with states SHOW_A and SHOW_B. Reset state is SHOW_A.
  - A toggle event moves SHOW_A↔SHOW_B.
  - Toggle event = press OR (auto_en && auto_cnt == AUTO_CYCLES-1).
- Auto counter auto_cnt, ceil(log2(AUTO_CYCLES)) bits:
  - Clears on reset, on auto_en == 0, on any press, and on reaching AUTO_CYCLES-1.
  - Otherwise increments while auto_en == 1.
- Outputs (all registered):
  - sel = (next state == SHOW_B).
  - digits = DATE_B when next state is SHOW_B, else DATE_A.
  - press_pulse = 1 for exactly the cycle sel reflects a press-caused toggle.
- Reset values: digits = DATE_A, sel = 0, press_pulse = 0. All internal counters are 0. Sync flops and key_db are 1.

## Timing
- Press latency: key_n first sampled low at edge 0, held low. key_s is low after edge 2. key_db falls at edge DEBOUNCE_CYCLES+2. sel, digits and press_pulse update at edge DEBOUNCE_CYCLES+3.
- Auto period: with auto_en held high and no presses, sel toggles every AUTO_CYCLES clocks exactly. The first toggle occurs AUTO_CYCLES clocks after auto_en is first sampled high.
- Press and auto terminal count in the same cycle: exactly one toggle. press_pulse = 1 and auto_cnt clears.
- Holding the button: one toggle only. A new press requires key_db to return to 1 first.
- auto_en deasserting mid-count: the counter clears next edge and no toggle occurs. Reasserting restarts a full period.
- rst asserted at any time, including mid-debounce or on the terminal auto count: all state returns to reset values on that edge. Any pending press is discarded. A button still held after reset release is not a press until released and pressed again, because key_db returns to 1 only after a stable release… then falls on a fresh press.
- digits and sel never change in the same cycle as rst is sampled high, except to their reset values.

## Structure
- Shared package date_disp_pkg:
  - Default DATE_A/DATE_B constants.
  - The date_state_t enum (SHOW_A, SHOW_B).
  - A BCD digit typedef (logic [3:0]).
- Sub-module key_debounce:
  - Parameter DEBOUNCE_CYCLES.
  - Ports: clock, rst, key_n in; key_db and press strobe out.
  - Contains the synchroniser and debouncer.
- The top contains the FSM, the auto counter and the output registers.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, AUTO_CYCLES=10.
- Reset check: rst high 2 cycles, then low. Expect digits=24'h030200, sel=0, press_pulse=0.
- Clean press: key_n low at edge 0, held 20 cycles. Expect sel=1, digits=24'h080700 and a single press_pulse at edge 7. No further change during hold or on release.
- Glitch rejection: key_n low for 3 cycles, then high. Expect sel, digits and press_pulse unchanged throughout.
- Auto alternation: auto_en=1 from edge 0, no presses. Expect sel toggles at edges 10, 20, 30, with digits alternating 24'h080700/24'h030200. press_pulse stays 0.
- Simultaneous events: with auto_en=1, time a press so key_db falls on the auto terminal count. Expect exactly one toggle, press_pulse=1, and the next auto toggle 10 cycles later.
- Reset mid-operation: assert rst 2 cycles into the debounce window with key_n held low, and separately with sel=1. Expect reset values. No toggle after rst is released until the button is released and pressed again.
